// File: rtl/testbench_ls_input_pio_irq.sv
// Parallel input port with per-bit rise/fall edge capture, interrupt mask and a
// saturating event counter, exposed through a small register interface.
module testbench_ls_input_pio_irq #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RISE_RESET  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] AddrData  = 3'd0;
  localparam logic [2:0] AddrMask  = 3'd1;
  localparam logic [2:0] AddrRise  = 3'd2;
  localparam logic [2:0] AddrEdge  = 3'd3;
  localparam logic [2:0] AddrFall  = 3'd4;
  localparam logic [2:0] AddrCount = 3'd5;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] sync, prev_q;
  logic [WIDTH-1:0] irq_mask_q, rise_en_q, fall_en_q, edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] event_bits, wdata;
  logic [15:0]      event_cnt_q, event_cnt_d;
  logic [31:0]      readdata_d;
  logic             wr, any_event;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry register contents.
  assign unused_wdata = ^writedata;
  assign wdata        = writedata[WIDTH-1:0];
  assign wr           = chipselect & ~write_n;

  assign sync       = chain_q[SYNC_STAGES-1];
  assign event_bits = (rise_en_q & sync & ~prev_q) | (fall_en_q & ~sync & prev_q);
  assign any_event  = |event_bits;

  assign irq = |(edge_cap_q & irq_mask_q);

  // Synchroniser chain; prev holds the previous synchronised value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        chain_q <= {chain_q[SYNC_STAGES-2:0], in_port};
      end
      prev_q <= sync;
    end
  end

  // Capture and counter next state; a new event overrides a same-cycle clear.
  always_comb begin
    edge_cap_d = edge_cap_q;
    if (wr && address == AddrEdge) begin
      edge_cap_d = edge_cap_q & ~wdata;
    end
    edge_cap_d = edge_cap_d | event_bits;

    event_cnt_d = event_cnt_q;
    if (wr && address == AddrCount) begin
      event_cnt_d = any_event ? 16'd1 : 16'd0;
    end else if (any_event && event_cnt_q != 16'hFFFF) begin
      event_cnt_d = event_cnt_q + 16'd1;
    end
  end

  // Read mux, sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:  readdata_d[WIDTH-1:0] = sync;
      AddrMask:  readdata_d[WIDTH-1:0] = irq_mask_q;
      AddrRise:  readdata_d[WIDTH-1:0] = rise_en_q;
      AddrEdge:  readdata_d[WIDTH-1:0] = edge_cap_q;
      AddrFall:  readdata_d[WIDTH-1:0] = fall_en_q;
      AddrCount: readdata_d[15:0]      = event_cnt_q;
      default:   readdata_d            = '0;
    endcase
  end

  // Control registers, capture, counter and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q  <= '0;
      rise_en_q   <= RISE_RESET;
      fall_en_q   <= '0;
      edge_cap_q  <= '0;
      event_cnt_q <= '0;
      readdata    <= '0;
    end else begin
      if (wr && address == AddrMask) irq_mask_q <= wdata;
      if (wr && address == AddrRise) rise_en_q  <= wdata;
      if (wr && address == AddrFall) fall_en_q  <= wdata;
      edge_cap_q  <= edge_cap_d;
      event_cnt_q <= event_cnt_d;
      readdata    <= readdata_d;
    end
  end

endmodule
